xt_hb_arbiter: RTL and testbench

Multi-master arbiter and address decoder for the XT_HB high-speed bus. It is the next generation of the single-master XT_HB fabric, for SoC builds that add a second bus master (DMA, debug) next to the RISC-V core. It arbitrates up to MASTER_NUM masters round-robin and decodes addresses onto DEVICE_NUM devices. It stalls each master until its access finishes, and ends hung accesses with a timeout error.

---
 rtl/xt_hb_arbiter_if.sv | 45 ++++
 rtl/xt_hb_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_xt_hb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xt_hb_arbiter_if.sv
// XT_HB multi-master bus bundle: master request/response lines on one side,
// device select/finish lines on the other. The arbiter connects through the
// slave modport, because it serves the masters' requests.
interface xt_hb_arbiter_if #(
  parameter int MASTER_NUM = 2,
  parameter int DEVICE_NUM = 5,
  parameter int ADDR_WIDTH = 32
);
  // Master side
  logic [MASTER_NUM-1:0]                 m_read;
  logic [MASTER_NUM-1:0]                 m_write;
  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_raddr;
  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_waddr;
  logic [MASTER_NUM-1:0][31:0]           m_wdata;
  logic [MASTER_NUM-1:0][1:0]            m_write_width;
  logic [MASTER_NUM-1:0]                 stall_req;
  logic [MASTER_NUM-1:0]                 bus_err;
  logic [31:0]                           hb_rdata;

  // Device side
  logic [DEVICE_NUM-1:0]                 dev_read;
  logic [DEVICE_NUM-1:0]                 dev_write;
  logic [ADDR_WIDTH-1:0]                 bus_addr;
  logic [31:0]                           bus_wdata;
  logic [1:0]                            bus_write_width;
  logic [DEVICE_NUM-1:0][31:0]           dev_rdata;
  logic [DEVICE_NUM-1:0]                 read_finish;
  logic [DEVICE_NUM-1:0]                 write_finish;

  // Arbiter view
  modport slave (
    input  m_read, m_write, m_raddr, m_waddr, m_wdata, m_write_width,
    input  dev_rdata, read_finish, write_finish,
    output stall_req, bus_err, hb_rdata,
    output dev_read, dev_write, bus_addr, bus_wdata, bus_write_width
  );

  // Masters-plus-devices view
  modport master (
    output m_read, m_write, m_raddr, m_waddr, m_wdata, m_write_width,
    output dev_rdata, read_finish, write_finish,
    input  stall_req, bus_err, hb_rdata,
    input  dev_read, dev_write, bus_addr, bus_wdata, bus_write_width
  );
endinterface

// File: rtl/xt_hb_arbiter.sv
// XT_HB multi-master arbiter and address decoder.
// Round-robin grant among requesting masters, one access at a time; an access
// is an optional write followed by an optional read. Each phase is bounded by
// a timeout that abandons the rest of the access and flags bus_err.
module xt_hb_arbiter #(
  parameter int MASTER_NUM = 2,
  parameter int DEVICE_NUM = 5,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] DEVICE_BASE_ADDR [DEVICE_NUM-1] =
    '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            hb_clk,
  input logic            rst_sync,
  xt_hb_arbiter_if.slave bus
);

  localparam int GW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef logic [GW-1:0] midx_t;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Highest device whose base is at or below the address; device 0 otherwise.
  function automatic logic [DEVICE_NUM-1:0] dec_onehot(input logic [ADDR_WIDTH-1:0] a);
    int hit;
    logic [DEVICE_NUM-1:0] oh;
    hit = 0;
    for (int k = 1; k < DEVICE_NUM; k++) begin
      hit = (a >= DEVICE_BASE_ADDR[k-1]) ? k : hit;
    end
    for (int d = 0; d < DEVICE_NUM; d++) begin
      oh[d] = (hit == d);
    end
    return oh;
  endfunction

  function automatic logic [MASTER_NUM-1:0] grant_onehot(input midx_t g);
    logic [MASTER_NUM-1:0] oh;
    for (int i = 0; i < MASTER_NUM; i++) begin
      oh[i] = (midx_t'(i) == g);
    end
    return oh;
  endfunction

  state_t                  state_r, state_nxt;
  midx_t                   last_grant_r, last_grant_nxt;
  midx_t                   grant_r, grant_nxt;
  logic [ADDR_WIDTH-1:0]   raddr_r, raddr_nxt;
  logic                    rd_flag_r, rd_flag_nxt;
  logic [15:0]             cnt_r, cnt_nxt;
  logic [MASTER_NUM-1:0]   ack_r, ack_nxt;
  logic [MASTER_NUM-1:0]   bus_err_r, bus_err_nxt;
  logic [31:0]             hb_rdata_r, hb_rdata_nxt;
  logic [DEVICE_NUM-1:0]   dev_read_r, dev_read_nxt;
  logic [DEVICE_NUM-1:0]   dev_write_r, dev_write_nxt;
  logic [ADDR_WIDTH-1:0]   bus_addr_r, bus_addr_nxt;
  logic [31:0]             bus_wdata_r, bus_wdata_nxt;
  logic [1:0]              bus_width_r, bus_width_nxt;

  logic [MASTER_NUM-1:0]   req_s;
  logic                    pick_found_s;
  midx_t                   pick_idx_s;
  logic                    wr_fin_s;
  logic                    rd_fin_s;
  logic [31:0]             rdata_sel_s;

  // A master stays stalled until the cycle its ack is pulsed.
  assign req_s    = (bus.m_read | bus.m_write) & ~ack_r;
  // Only the selected device's finish of the matching type counts.
  assign wr_fin_s = |(bus.write_finish & dev_write_r);
  assign rd_fin_s = |(bus.read_finish & dev_read_r);

  assign bus.stall_req       = req_s;
  assign bus.bus_err         = bus_err_r;
  assign bus.hb_rdata        = hb_rdata_r;
  assign bus.dev_read        = dev_read_r;
  assign bus.dev_write       = dev_write_r;
  assign bus.bus_addr        = bus_addr_r;
  assign bus.bus_wdata       = bus_wdata_r;
  assign bus.bus_write_width = bus_width_r;

  // Round-robin pick: first requester after the last grant, wrapping around.
  always_comb begin
    int cand;
    cand         = 0;
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = 1; k <= MASTER_NUM; k++) begin
      cand = (int'(last_grant_r) + k) % MASTER_NUM;
      if (!pick_found_s && req_s[cand]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = midx_t'(cand);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Read data mux driven by the one-hot read select.
  always_comb begin
    rdata_sel_s = 32'h0;
    for (int d = 0; d < DEVICE_NUM; d++) begin
      if (dev_read_r[d]) begin
        rdata_sel_s = rdata_sel_s | bus.dev_rdata[d];
      end else begin
        rdata_sel_s = rdata_sel_s;
      end
    end
  end

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_nxt      = state_r;
    last_grant_nxt = last_grant_r;
    grant_nxt      = grant_r;
    raddr_nxt      = raddr_r;
    rd_flag_nxt    = rd_flag_r;
    cnt_nxt        = cnt_r;
    ack_nxt        = '0;
    bus_err_nxt    = '0;
    hb_rdata_nxt   = hb_rdata_r;
    dev_read_nxt   = dev_read_r;
    dev_write_nxt  = dev_write_r;
    bus_addr_nxt   = bus_addr_r;
    bus_wdata_nxt  = bus_wdata_r;
    bus_width_nxt  = bus_width_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          grant_nxt     = pick_idx_s;
          raddr_nxt     = bus.m_raddr[pick_idx_s];
          rd_flag_nxt   = bus.m_read[pick_idx_s];
          bus_wdata_nxt = bus.m_wdata[pick_idx_s];
          bus_width_nxt = bus.m_write_width[pick_idx_s];
          cnt_nxt       = 16'd0;
          if (bus.m_write[pick_idx_s]) begin
            state_nxt     = WRITE;
            bus_addr_nxt  = bus.m_waddr[pick_idx_s];
            dev_write_nxt = dec_onehot(bus.m_waddr[pick_idx_s]);
          end else begin
            state_nxt    = READ;
            bus_addr_nxt = bus.m_raddr[pick_idx_s];
            dev_read_nxt = dec_onehot(bus.m_raddr[pick_idx_s]);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        if (wr_fin_s) begin
          dev_write_nxt = '0;
          cnt_nxt       = 16'd0;
          if (rd_flag_r) begin
            state_nxt    = READ;
            bus_addr_nxt = raddr_r;
            dev_read_nxt = dec_onehot(raddr_r);
          end else begin
            state_nxt = DONE;
            ack_nxt   = grant_onehot(grant_r);
          end
        end else if (cnt_r == TO_LAST) begin
          // Hung write: the pending read is dropped as well.
          dev_write_nxt = '0;
          state_nxt     = DONE;
          ack_nxt       = grant_onehot(grant_r);
          bus_err_nxt   = grant_onehot(grant_r);
          hb_rdata_nxt  = 32'h0;
        end else begin
          cnt_nxt = cnt_r + 16'd1;
        end
      end
      READ: begin
        if (rd_fin_s) begin
          dev_read_nxt = '0;
          state_nxt    = DONE;
          ack_nxt      = grant_onehot(grant_r);
          hb_rdata_nxt = rdata_sel_s;
        end else if (cnt_r == TO_LAST) begin
          dev_read_nxt = '0;
          state_nxt    = DONE;
          ack_nxt      = grant_onehot(grant_r);
          bus_err_nxt  = grant_onehot(grant_r);
          hb_rdata_nxt = 32'h0;
        end else begin
          cnt_nxt = cnt_r + 16'd1;
        end
      end
      DONE: begin
        state_nxt      = IDLE;
        last_grant_nxt = grant_r;
      end
      default: begin
        state_nxt     = IDLE;
        dev_read_nxt  = '0;
        dev_write_nxt = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge hb_clk or posedge rst_sync) begin
    if (rst_sync) begin
      state_r      <= IDLE;
      last_grant_r <= midx_t'(MASTER_NUM - 1);
      grant_r      <= '0;
      raddr_r      <= '0;
      rd_flag_r    <= 1'b0;
      cnt_r        <= 16'd0;
      ack_r        <= '0;
      bus_err_r    <= '0;
      hb_rdata_r   <= 32'h0;
      dev_read_r   <= '0;
      dev_write_r  <= '0;
      bus_addr_r   <= '0;
      bus_wdata_r  <= 32'h0;
      bus_width_r  <= 2'd0;
    end else begin
      state_r      <= state_nxt;
      last_grant_r <= last_grant_nxt;
      grant_r      <= grant_nxt;
      raddr_r      <= raddr_nxt;
      rd_flag_r    <= rd_flag_nxt;
      cnt_r        <= cnt_nxt;
      ack_r        <= ack_nxt;
      bus_err_r    <= bus_err_nxt;
      hb_rdata_r   <= hb_rdata_nxt;
      dev_read_r   <= dev_read_nxt;
      dev_write_r  <= dev_write_nxt;
      bus_addr_r   <= bus_addr_nxt;
      bus_wdata_r  <= bus_wdata_nxt;
      bus_width_r  <= bus_width_nxt;
    end
  end

endmodule

// File: tb/tb_xt_hb_arbiter.sv
// Bench for xt_hb_arbiter: directed scenarios followed by random multi-master
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_xt_hb_arbiter;
  localparam int M  = 2;
  localparam int D  = 5;
  localparam int AW = 32;
  localparam int T  = 4;
  localparam logic [31:0] BASE [D-1] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xt_hb_arbiter_if #(.MASTER_NUM(M), .DEVICE_NUM(D), .ADDR_WIDTH(AW)) bus ();

  xt_hb_arbiter #(
    .MASTER_NUM(M), .DEVICE_NUM(D), .ADDR_WIDTH(AW),
    .DEVICE_BASE_ADDR(BASE), .TIMEOUT_CYCLES(T)
  ) dut (
    .hb_clk(clk),
    .rst_sync(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model state: one outstanding transaction per master.
  bit          pend    [M];
  bit          t_rd    [M];
  bit          t_wr    [M];
  logic [31:0] t_raddr [M];
  logic [31:0] t_waddr [M];
  logic [31:0] t_wdata [M];
  logic [1:0]  t_width [M];
  int          t_wdly  [M];   // finish delay in cycles; >= T means never
  int          t_rdly  [M];
  int          last_g;
  logic [31:0] hb_exp;
  logic [31:0] dev_data [D];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Device index = number of base addresses at or below a (bases ascend).
  function automatic int ref_dev(input logic [31:0] a);
    int n;
    n = 0;
    foreach (BASE[k]) if (a >= BASE[k]) n++;
    return n;
  endfunction

  // Next grant: lowest pending index above the last grant, else lowest overall.
  function automatic int ref_pick();
    int best;
    best = -1;
    for (int i = M - 1; i > last_g; i--) if (pend[i]) best = i;
    if (best < 0) begin
      for (int i = last_g; i >= 0; i--) if (pend[i]) best = i;
    end
    return best;
  endfunction

  function automatic logic [M-1:0] pend_vec();
    logic [M-1:0] v;
    for (int i = 0; i < M; i++) v[i] = pend[i];
    return v;
  endfunction

  function automatic logic [31:0] rnd_addr();
    int d;
    logic [63:0] lo, hi;
    d = $urandom_range(0, D - 1);
    if (d == 0) lo = 64'h0; else lo = 64'(BASE[d-1]);
    if (d == D - 1) hi = 64'hFFFF_FFFF; else hi = 64'(BASE[d]) - 64'h1;
    case ($urandom_range(0, 2))
      0:       return lo[31:0];
      1:       return hi[31:0];
      default: return 32'(lo + (64'($urandom) % (hi - lo + 64'h1)));
    endcase
  endfunction

  task automatic set_txn(input int i, input bit wr, input bit rd, input logic [31:0] waddr,
                         input logic [31:0] raddr, input logic [31:0] wdata,
                         input logic [1:0] width, input int wdly, input int rdly);
    pend[i] = 1'b1; t_wr[i] = wr; t_rd[i] = rd;
    t_waddr[i] = waddr; t_raddr[i] = raddr; t_wdata[i] = wdata;
    t_width[i] = width; t_wdly[i] = wdly; t_rdly[i] = rdly;
  endtask

  task automatic rand_txn(input int i);
    int op;
    op = $urandom_range(0, 2);   // 0 read, 1 write, 2 write then read
    set_txn(i, op != 0, op != 1, rnd_addr(), rnd_addr(), $urandom,
            2'($urandom_range(0, 2)), $urandom_range(0, T), $urandom_range(0, T));
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < M; i++) begin
      bus.m_read[i]        = pend[i] & t_rd[i];
      bus.m_write[i]       = pend[i] & t_wr[i];
      bus.m_raddr[i]       = t_raddr[i];
      bus.m_waddr[i]       = t_waddr[i];
      bus.m_wdata[i]       = t_wdata[i];
      bus.m_write_width[i] = t_width[i];
    end
    for (int d = 0; d < D; d++) bus.dev_rdata[d] = dev_data[d];
  endtask

  // phase 0: no access phase, 1: write phase, 2: read phase. Random finish
  // pulses go to every line the arbiter must ignore.
  task automatic set_fin(input int phase, input int dev, input bit fin);
    logic [D-1:0] sel, nr, nw;
    sel = '0;
    if (phase != 0) sel[dev] = 1'b1;
    nr = D'($urandom);
    nw = D'($urandom);
    if (phase == 1) begin
      bus.write_finish = (nw & ~sel) | (fin ? sel : '0);
      bus.read_finish  = nr;
    end else if (phase == 2) begin
      bus.read_finish  = (nr & ~sel) | (fin ? sel : '0);
      bus.write_finish = nw;
    end else begin
      bus.read_finish  = nr;
      bus.write_finish = nw;
    end
  endtask

  // Called at the negedge of a select cycle; returns at the negedge after the phase.
  task automatic run_phase(input int phase, input int g, output bit to);
    int dev, dly;
    bit fin;
    logic [31:0] addr;
    logic [D-1:0] exp_sel;
    addr = (phase == 1) ? t_waddr[g] : t_raddr[g];
    dly  = (phase == 1) ? t_wdly[g] : t_rdly[g];
    dev  = ref_dev(addr);
    exp_sel = '0;
    exp_sel[dev] = 1'b1;
    to = 1'b1;
    for (int c = 0; c < T && to; c++) begin
      check_val("phase_stall", bus.stall_req, pend_vec());
      check_val(phase == 1 ? "dev_write" : "dev_read", phase == 1 ? bus.dev_write : bus.dev_read, exp_sel);
      check_val("other_sel_low", phase == 1 ? bus.dev_read : bus.dev_write, '0);
      check_val("bus_addr", bus.bus_addr, addr);
      if (phase == 1) begin
        check_val("bus_wdata", bus.bus_wdata, t_wdata[g]);
        check_val("bus_write_width", bus.bus_write_width, t_width[g]);
      end
      fin = (c == dly);
      set_fin(phase, dev, fin);
      @(negedge clk);
      if (fin) to = 1'b0;
    end
  endtask

  // Called at the negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle.
  task automatic run_access();
    int g;
    bit to;
    logic [M-1:0] gmask;
    drive_reqs();
    set_fin(0, 0, 1'b0);
    #1;
    check_val("idle_stall", bus.stall_req, pend_vec());
    g = ref_pick();
    @(negedge clk);
    to = 1'b0;
    if (t_wr[g]) run_phase(1, g, to);
    if (t_rd[g] && !to) run_phase(2, g, to);
    if (to) hb_exp = 32'h0;
    else if (t_rd[g]) hb_exp = dev_data[ref_dev(t_raddr[g])];
    gmask = '0;
    gmask[g] = 1'b1;
    check_val("done_stall", bus.stall_req, pend_vec() & ~gmask);
    check_val("bus_err", bus.bus_err, to ? gmask : '0);
    check_val("hb_rdata", bus.hb_rdata, hb_exp);
    check_val("done_deselect", {bus.dev_read, bus.dev_write}, '0);
    set_fin(0, 0, 1'b0);
    last_g = g;
    pend[g] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < M; i++) begin
      pend[i] = 1'b0; t_rd[i] = 1'b0; t_wr[i] = 1'b0;
      t_raddr[i] = 32'h0; t_waddr[i] = 32'h0; t_wdata[i] = 32'h0;
      t_width[i] = 2'd0; t_wdly[i] = 0; t_rdly[i] = 0;
    end
    for (int d = 0; d < D; d++) dev_data[d] = 32'h0;
    drive_reqs();
    set_fin(0, 0, 1'b0);
    last_g = M - 1;
    hb_exp = 32'h0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    check_val("rst_stall", bus.stall_req, '0);
    check_val("rst_sel", {bus.dev_read, bus.dev_write}, '0);
    check_val("rst_bus_addr", bus.bus_addr, '0);
    check_val("rst_bus_wdata", bus.bus_wdata, '0);
    check_val("rst_width", bus.bus_write_width, '0);
    check_val("rst_hb_rdata", bus.hb_rdata, '0);
    check_val("rst_bus_err", bus.bus_err, '0);
    rst = 1'b0;

    // Single read of device 2, finish together with the select
    dev_data[2] = 32'hA5A5_0001;
    set_txn(0, 1'b0, 1'b1, 32'h0, 32'h0000_2004, 32'h0, 2'd0, 0, 0);
    run_access();

    // Decode boundaries
    set_txn(0, 1'b0, 1'b1, 32'h0, 32'h0000_1FFF, 32'h0, 2'd0, 0, 1);
    run_access();
    set_txn(1, 1'b0, 1'b1, 32'h0, 32'h0000_2000, 32'h0, 2'd0, 0, 2);
    run_access();
    set_txn(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'hDEAD_BEEF, 2'd0, 1, 0);
    run_access();
    set_txn(1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_00FF, 2'd1, 3, 0);
    run_access();

    // Write then read from one master
    dev_data[0] = 32'h0BAD_F00D;
    set_txn(1, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_0010, 32'h1234_5678, 2'd2, 0, 0);
    run_access();

    // Hung read times out, the other master follows normally
    set_txn(0, 1'b0, 1'b1, 32'h0, 32'h0000_4010, 32'h0, 2'd0, 0, T);
    set_txn(1, 1'b0, 1'b1, 32'h0, 32'h0000_1000, 32'h0, 2'd0, 0, 0);
    dev_data[1] = 32'h5555_AAAA;
    run_access();
    run_access();

    // Both masters requesting continuously
    rand_txn(0);
    rand_txn(1);
    for (int k = 0; k < 6; k++) begin
      run_access();
      rand_txn(last_g);
    end
    // Drain until no request remains
    while (pend_vec() != '0) run_access();

    // Reset pulsed in the middle of a read
    set_txn(0, 1'b0, 1'b1, 32'h0, 32'h0000_2100, 32'h0, 2'd0, 0, T);
    drive_reqs();
    @(negedge clk);
    check_val("pre_rst_sel", bus.dev_read, 5'b00100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_mid_sel", {bus.dev_read, bus.dev_write}, '0);
    check_val("rst_mid_rdata", bus.hb_rdata, '0);
    check_val("rst_mid_addr", bus.bus_addr, '0);
    @(negedge clk);
    rst = 1'b0;
    last_g = M - 1;
    hb_exp = 32'h0;
    dev_data[4] = 32'h0F0F_0F0F;
    set_txn(0, 1'b0, 1'b1, 32'h0, 32'h0000_4000, 32'h0, 2'd0, 0, 1);
    set_txn(1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 32'h0000_0042, 2'd0, 0, 0);
    run_access();
    run_access();

    // Random multi-master traffic
    for (int n = 0; n < 150; n++) begin
      for (int d = 0; d < D; d++) dev_data[d] = $urandom;
      for (int i = 0; i < M; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) rand_txn(i);
      end
      if (pend_vec() == '0) rand_txn($urandom_range(0, M - 1));
      run_access();
    end

    for (int i = 0; i < M; i++) pend[i] = 1'b0;
    drive_reqs();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
